// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
// Shared constants for the DRAM path (dram_arbiter, dram_control, dram_test).
//   ADDR_W      : line address width
//   DATA_W      : line data width (one 128-bit line per transaction)
//   arb_state_t : arbiter FSM encoding (IDLE / BUSY)
// -----------------------------------------------------------------------------
package dram_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage : dram_pkg

// File: rtl/dram_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority pick. It searches the request vector
// starting at i_ptr and moving upward with wrap-around. It returns the first
// set bit.
//   i_valid : request vector, one bit per port
//   i_ptr   : index of the highest-priority port
//   o_hit   : at least one request is set
//   o_idx   : index of the selected port (0 when o_hit is low)
// -----------------------------------------------------------------------------
module rr_pick
    import dram_pkg::*;
#(
    parameter  int NPORTS = 2,
    localparam int IDX_W  = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] i_valid,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    // w_cand[k] is the port that sits k places after i_ptr in priority order.
    logic [IDX_W-1:0] w_cand      [NPORTS];
    logic [NPORTS-1:0] w_rot_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_rot
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, i_ptr} + (IDX_W+1)'(gi);
            // i_ptr is always < NPORTS, so one conditional subtract is a full modulo.
            assign w_cand[gi] = (w_sum >= (IDX_W+1)'(NPORTS))
                              ? IDX_W'(w_sum - (IDX_W+1)'(NPORTS))
                              : IDX_W'(w_sum);
            assign w_rot_valid[gi] = i_valid[w_cand[gi]];
        end
    endgenerate

    // Scan from the lowest priority to the highest so that the nearest request wins.
    always_comb begin
        o_hit = |i_valid;
        o_idx = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (w_rot_valid[k]) begin
                o_idx = w_cand[k];
            end
        end
    end

endmodule : rr_pick

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Round-robin arbiter that shares the single dram_control request port among
// NPORTS requesters. It handles one 128-bit line transaction at a time. All
// outputs are registered.
//   clk, rstn              : clock and asynchronous active-low reset
//   req_valid/addr/wmask/  : per-port requests (packed, port i at [i*W +: W])
//   req_wdata
//   req_ready              : one-cycle completion strobe to the winning port
//   req_rdata              : read data, qualified by req_ready[i]
//   mem_valid/addr/wmask/  : request to dram_control, held stable while busy
//   mem_wdata
//   mem_ready/mem_rdata    : completion from dram_control
//   grant                  : port owning the current or last transaction
//   busy                   : a transaction is outstanding
// -----------------------------------------------------------------------------
module dram_arbiter
    import dram_pkg::*;
#(
    parameter  int NPORTS = 2,
    parameter  int ADDR_W = dram_pkg::ADDR_W,
    parameter  int DATA_W = dram_pkg::DATA_W,
    localparam int IDX_W  = $clog2(NPORTS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NPORTS-1:0]        req_valid,
    output logic [NPORTS-1:0]        req_ready,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS-1:0]        req_wmask,
    input  logic [NPORTS*DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_wmask,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [IDX_W-1:0]         grant,
    output logic                     busy
);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [NPORTS-1:0]  r_req_ready;
    logic [DATA_W-1:0]  r_req_rdata;
    logic               r_mem_valid;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_wmask;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_busy;

    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic [ADDR_W-1:0]  w_addr_arr  [NPORTS];
    logic [DATA_W-1:0]  w_wdata_arr [NPORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .NPORTS (NPORTS)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_hit   (w_hit),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_req_rdata <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wmask <= 1'b0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            // The completion strobe lasts exactly one cycle.
            r_req_ready <= '0;
            case (r_state)
                ST_IDLE: begin
                    // mem_ready is ignored here. Leaving IDLE for at least one
                    // cycle gives dram_control its mem_valid low gap.
                    if (w_hit) begin
                        r_grant     <= w_idx;
                        r_mem_addr  <= w_addr_arr[w_idx];
                        r_mem_wmask <= req_wmask[w_idx];
                        r_mem_wdata <= w_wdata_arr[w_idx];
                        r_mem_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        r_req_ready[r_grant] <= 1'b1;
                        r_req_rdata          <= mem_rdata;
                        r_mem_valid          <= 1'b0;
                        r_busy               <= 1'b0;
                        // The port just served drops to the lowest priority.
                        r_rr_ptr             <= (r_grant == IDX_W'(NPORTS - 1))
                                              ? '0 : r_grant + 1'b1;
                        r_state              <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign req_rdata = r_req_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wmask = r_mem_wmask;
    assign mem_wdata = r_mem_wdata;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule : dram_arbiter
